cla_accum_pipe: RTL and testbench

Parametrised, two-stage pipelined carry-lookahead adder/accumulator for the NPU datapath, generalising the fixed 19→20-bit CLA adder. It performs signed add, subtract, accumulator load and accumulate on IN_W-bit operands into an ACC_W-bit result. The lookahead is built from GRP_W-bit CLA groups. Valid/ready handshakes are on both sides. It sits between the multiplier array outputs and the activation/writeback stage.

---
 rtl/npu_arith_pkg.sv | 20 ++
 rtl/cla_group_n.sv | 55 +++++
 rtl/cla_accum_pipe.sv | 173 +++++++++++++++++
 tb/tb_cla_accum_pipe.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/npu_arith_pkg.sv
// Shared arithmetic types and helpers for the NPU datapath adders.
// Saturation bounds come back as 64-bit two's complement; callers slice them to width.
package npu_arith_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ACC  = 2'b10,
    OP_LOAD = 2'b11
  } op_mode_e;

  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction

endpackage

// File: rtl/cla_group_n.sv
// One GRP_W-bit carry-lookahead group: local sum, group generate/propagate,
// and the carry into its MSB so the top can detect signed overflow.
module cla_group_n #(
  parameter int GRP_W = 4
) (
  input  logic [GRP_W-1:0] a_i,
  input  logic [GRP_W-1:0] b_i,
  input  logic             cin_i,
  output logic [GRP_W-1:0] sum_o,
  output logic             gg_o,
  output logic             pg_o,
  output logic             c_msb_o
);

  logic [GRP_W-1:0] gen;
  logic [GRP_W-1:0] prop;
  logic [GRP_W-1:0] carry;
  logic             chain;
  logic             term;

  assign gen  = a_i & b_i;
  assign prop = a_i ^ b_i;

  // Every bit carry is a flat sum of products of g/p and cin, no ripple.
  always_comb begin
    carry = '0;
    chain = 1'b0;
    term  = 1'b0;
    for (int i = 0; i < GRP_W; i++) begin
      chain = cin_i;
      for (int j = 0; j < i; j++) chain = chain & prop[j];
      for (int j = 0; j < i; j++) begin
        term = gen[j];
        for (int k = j + 1; k < i; k++) term = term & prop[k];
        chain = chain | term;
      end
      carry[i] = chain;
    end
  end

  always_comb begin
    gg_o = 1'b0;
    for (int j = 0; j < GRP_W; j++) begin
      logic t;
      t = gen[j];
      for (int k = j + 1; k < GRP_W; k++) t = t & prop[k];
      gg_o = gg_o | t;
    end
  end

  assign pg_o    = &prop;
  assign sum_o   = prop ^ carry;
  assign c_msb_o = carry[GRP_W-1];

endmodule

// File: rtl/cla_accum_pipe.sv
// Two-stage pipelined CLA adder/accumulator: operand register stage, then a
// single-level group lookahead with saturating accumulate and a held output register.
module cla_accum_pipe
  import npu_arith_pkg::*;
#(
  parameter int IN_W   = 19,
  parameter int ACC_W  = 24,
  parameter int GRP_W  = 4,
  parameter int SAT_EN = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [1:0]        mode_i,
  input  logic [IN_W-1:0]   a_i,
  input  logic [IN_W-1:0]   b_i,
  input  logic              last_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              overflow_o
);

  localparam int N_GRP = ACC_W / GRP_W;
  localparam int EXT_W = ACC_W - IN_W;
  localparam logic [63:0]      SAT_MAX64 = sat_max(ACC_W);
  localparam logic [63:0]      SAT_MIN64 = sat_min(ACC_W);
  localparam logic [ACC_W-1:0] SAT_MAX   = SAT_MAX64[ACC_W-1:0];
  localparam logic [ACC_W-1:0] SAT_MIN   = SAT_MIN64[ACC_W-1:0];

  logic             stall;
  op_mode_e         mode_in;
  logic [ACC_W-1:0] a_ext, b_ext, s1_b_d;

  logic             s1_valid_q, s1_last_q;
  op_mode_e         s1_mode_q;
  logic [ACC_W-1:0] s1_a_q, s1_b_q;

  logic [ACC_W-1:0] acc_q, acc_d, sum_q, sum_d;
  logic             ovf_acc_q, ovf_acc_d, out_valid_q, out_valid_d, ovf_q, ovf_d;

  logic [ACC_W-1:0] cla_x, cla_y, raw_sum, result;
  logic             cla_cin, c_msb, beat_ovf, is_accum, emit, advance;
  logic [N_GRP-1:0] grp_g, grp_p;
  logic [N_GRP:0]   grp_c;
  logic             la_chain, la_term;

  assign stall      = out_valid_q & ~out_ready_i;
  assign in_ready_o = ~stall;
  assign mode_in    = op_mode_e'(mode_i);
  assign a_ext      = {{EXT_W{a_i[IN_W-1]}}, a_i};
  assign b_ext      = {{EXT_W{b_i[IN_W-1]}}, b_i};
  assign s1_b_d     = (mode_in == OP_SUB) ? ~b_ext : b_ext;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_mode_q  <= OP_ADD;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else if (!stall) begin
      s1_valid_q <= in_valid_i;
      s1_last_q  <= last_i;
      s1_mode_q  <= mode_in;
      s1_a_q     <= a_ext;
      s1_b_q     <= s1_b_d;
    end
  end

  always_comb begin
    cla_x   = s1_a_q;
    cla_y   = s1_b_q;
    cla_cin = (s1_mode_q == OP_SUB);
    if (s1_mode_q == OP_ACC) begin
      cla_x = acc_q;
      cla_y = s1_a_q;
    end
  end

  // Group carries come straight from cin and all lower G/P terms in parallel.
  always_comb begin
    grp_c    = '0;
    la_chain = 1'b0;
    la_term  = 1'b0;
    grp_c[0] = cla_cin;
    for (int g = 1; g <= N_GRP; g++) begin
      la_chain = cla_cin;
      for (int j = 0; j < g; j++) la_chain = la_chain & grp_p[j];
      for (int j = 0; j < g; j++) begin
        la_term = grp_g[j];
        for (int k = j + 1; k < g; k++) la_term = la_term & grp_p[k];
        la_chain = la_chain | la_term;
      end
      grp_c[g] = la_chain;
    end
  end

  for (genvar gi = 0; gi < N_GRP; gi++) begin : g_grp
    logic grp_cmsb;
    cla_group_n #(.GRP_W(GRP_W)) u_grp (
      .a_i    (cla_x[gi*GRP_W +: GRP_W]),
      .b_i    (cla_y[gi*GRP_W +: GRP_W]),
      .cin_i  (grp_c[gi]),
      .sum_o  (raw_sum[gi*GRP_W +: GRP_W]),
      .gg_o   (grp_g[gi]),
      .pg_o   (grp_p[gi]),
      .c_msb_o(grp_cmsb)
    );
    if (gi == N_GRP - 1) begin : g_top
      assign c_msb = grp_cmsb;
    end else begin : g_low
      logic unused_cmsb;
      assign unused_cmsb = grp_cmsb;
    end
  end

  assign is_accum = (s1_mode_q == OP_ACC) || (s1_mode_q == OP_LOAD);
  assign beat_ovf = (s1_mode_q == OP_ACC) & (c_msb ^ grp_c[N_GRP]);
  assign emit     = s1_valid_q & (~is_accum | s1_last_q);
  assign advance  = s1_valid_q & ~stall;

  // Clamp direction follows A: overflow needs acc and A to share a sign.
  always_comb begin
    result = raw_sum;
    if (s1_mode_q == OP_LOAD) result = s1_a_q;
    else if (beat_ovf && (SAT_EN != 0)) result = s1_a_q[ACC_W-1] ? SAT_MIN : SAT_MAX;
  end

  always_comb begin
    acc_d       = acc_q;
    ovf_acc_d   = ovf_acc_q;
    out_valid_d = out_valid_q & ~out_ready_i;
    sum_d       = sum_q;
    ovf_d       = ovf_q;
    if (advance && is_accum) begin
      if (s1_last_q) begin
        acc_d     = '0;
        ovf_acc_d = 1'b0;
      end else begin
        acc_d     = result;
        ovf_acc_d = ovf_acc_q | beat_ovf;
      end
    end
    if (advance && emit) begin
      out_valid_d = 1'b1;
      sum_d       = result;
      ovf_d       = is_accum & (ovf_acc_q | beat_ovf);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q       <= '0;
      ovf_acc_q   <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      ovf_acc_q   <= ovf_acc_d;
      out_valid_q <= out_valid_d;
      sum_q       <= sum_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign sum_o       = sum_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_cla_accum_pipe.sv
// Directed bench for cla_accum_pipe: arithmetic, accumulate/saturate,
// backpressure and mid-accumulation reset, with hand-computed expectations.
module tb_cla_accum_pipe;
  import npu_arith_pkg::*;

  localparam int IN_W  = 19;
  localparam int ACC_W = 24;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, last, out_valid, out_ready, ovf;
  logic [1:0]        mode;
  logic [IN_W-1:0]   a, b;
  logic [ACC_W-1:0]  sum;

  int checkCount = 0;
  int failCount  = 0;

  logic [ACC_W-1:0] sumQ[$];
  logic             ovfQ[$];

  always #5 clk = ~clk;

  cla_accum_pipe #(.IN_W(IN_W), .ACC_W(ACC_W), .GRP_W(4), .SAT_EN(1)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .mode_i     (mode),
    .a_i        (a),
    .b_i        (b),
    .last_i     (last),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .sum_o      (sum),
    .overflow_o (ovf)
  );

  // Records every result the downstream side actually takes.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        sumQ.push_back(sum);
        ovfQ.push_back(ovf);
      end
    end
  end

  task automatic checkEq(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m, input int av, input int bv,
                               input logic l);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    mode     = m;
    a        = av[IN_W-1:0];
    b        = bv[IN_W-1:0];
    last     = l;
    @(negedge clk);
    while (in_ready !== 1'b1 && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (in_ready !== 1'b1) checkEq("accept_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input int expSum, input logic expOvf);
    int waited;
    logic [ACC_W-1:0] s;
    logic o;
    waited = 0;
    while (sumQ.size() == 0 && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (sumQ.size() == 0) begin
      checkEq({tag, "_timeout"}, sumQ.size(), 1);
    end else begin
      s = sumQ.pop_front();
      o = ovfQ.pop_front();
      checkEq({tag, "_sum"}, $signed(s), expSum);
      checkEq({tag, "_ovf"}, o, expOvf);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    mode = 2'b00; a = '0; b = '0; last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkEq("rst_out_valid", out_valid, 0);
    checkEq("rst_sum", $signed(sum), 0);
    checkEq("rst_ovf", ovf, 0);
    checkEq("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    $display("[TB] add/sub and latency");
    applyStimulus(OP_ADD, 262143, 262143, 1'b0);
    @(negedge clk);
    checkEq("lat_cycle1_valid", out_valid, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    checkEq("lat_cycle2_valid", out_valid, 1);
    checkEq("lat_cycle2_sum", $signed(sum), 524286);
    @(posedge clk);
    #1;
    checkOutput("add_max", 524286, 1'b0);
    applyStimulus(OP_ADD, -262144, -262144, 1'b0);
    checkOutput("add_min", -524288, 1'b0);
    applyStimulus(OP_SUB, -262144, 262143, 1'b0);
    checkOutput("sub_min", -524287, 1'b0);
    applyStimulus(OP_SUB, 5, 5, 1'b0);
    checkOutput("sub_zero", 0, 1'b0);

    // Back-to-back carry-chain cases at full rate.
    applyStimulus(OP_ADD, -1, 1, 1'b0);
    applyStimulus(OP_ADD, 262143, 1, 1'b0);
    applyStimulus(OP_SUB, 0, -262144, 1'b0);
    applyStimulus(OP_SUB, -1, 262143, 1'b0);
    applyStimulus(OP_ADD, 87381, 43690, 1'b0);
    applyStimulus(OP_SUB, 0, 0, 1'b0);
    checkOutput("chain_m1p1", 0, 1'b0);
    checkOutput("chain_max_p1", 262144, 1'b0);
    checkOutput("chain_0_mmin", 262144, 1'b0);
    checkOutput("chain_m1_mmax", -262144, 1'b0);
    checkOutput("chain_nocarry", 131071, 1'b0);
    checkOutput("chain_sub00", 0, 1'b0);

    $display("[TB] accumulate");
    applyStimulus(OP_LOAD, 100, 0, 1'b0);
    applyStimulus(OP_ACC, -30, 0, 1'b0);
    applyStimulus(OP_ACC, 5, 0, 1'b1);
    checkOutput("acc_75", 75, 1'b0);
    idle(4);
    checkEq("acc_single_output", sumQ.size(), 0);
    applyStimulus(OP_ADD, 1, 1, 1'b0);
    checkOutput("acc_then_add", 2, 1'b0);
    applyStimulus(OP_ACC, 9, 0, 1'b1);
    checkOutput("acc_restart", 9, 1'b0);

    $display("[TB] saturation");
    applyStimulus(OP_LOAD, 262143, 0, 1'b0);
    for (int i = 0; i < 32; i++) applyStimulus(OP_ACC, 262143, 0, (i == 31));
    checkOutput("sat_pos", 8388607, 1'b1);
    applyStimulus(OP_LOAD, 3, 0, 1'b1);
    checkOutput("sat_cleared", 3, 1'b0);
    applyStimulus(OP_LOAD, -262144, 0, 1'b0);
    for (int i = 0; i < 32; i++) applyStimulus(OP_ACC, -262144, 0, (i == 31));
    checkOutput("sat_neg", -8388608, 1'b1);
    applyStimulus(OP_LOAD, 262143, 0, 1'b0);
    for (int i = 0; i < 32; i++) applyStimulus(OP_ACC, 262143, 0, 1'b0);
    applyStimulus(OP_ACC, -1, 0, 1'b1);
    checkOutput("sat_sticky", 8388606, 1'b1);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(OP_ADD, 10, 20, 1'b0);
    applyStimulus(OP_SUB, 100, 1, 1'b0);
    in_valid = 1'b1; mode = OP_ADD; a = -19'sd5; b = -19'sd6; last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkEq("bp_in_ready", in_ready, 0);
      checkEq("bp_sum_hold", $signed(sum), 30);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    applyStimulus(OP_ADD, -5, -6, 1'b0);
    checkOutput("bp_first", 30, 1'b0);
    checkOutput("bp_second", 99, 1'b0);
    checkOutput("bp_third", -11, 1'b0);
    idle(4);
    checkEq("bp_no_dup", sumQ.size(), 0);

    $display("[TB] reset mid-accumulation");
    applyStimulus(OP_LOAD, 50, 0, 1'b0);
    applyStimulus(OP_ACC, 20, 0, 1'b0);
    applyStimulus(OP_ADD, 1, 1, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(4);
    checkEq("rst_no_output", sumQ.size(), 0);
    checkEq("rst_valid_low", out_valid, 0);
    applyStimulus(OP_LOAD, 7, 0, 1'b1);
    checkOutput("rst_reload", 7, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
